// File: rtl/fw_load_ctrl.sv
// Firmware loader: decodes framed UART load commands into instruction/data memory writes,
// holding the core in reset and owning the shared data-memory port while a load runs.
module fw_load_ctrl #(
  parameter int          IMEM_WORDS = 256,
  parameter int          DMEM_WORDS = 256,
  parameter logic [31:0] DMEM_BASE  = 32'h0000_0000,
  parameter logic [31:0] TIMEOUT    = 32'd50_000_000,
  localparam int         AW         = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  input  logic          core_we,
  input  logic [1:0]    core_mem_ctrl,
  input  logic [31:0]   core_addr,
  input  logic [31:0]   core_wdata,
  output logic          mem_we,
  output logic [1:0]    mem_ctrl,
  output logic [31:0]   mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  output logic          core_run,
  output logic          busy,
  output logic          load_done,
  output logic          load_err
);

  typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, CSUM, ERR} state_t;

  localparam logic [7:0] MAGIC_IMEM = 8'hA5;
  localparam logic [7:0] MAGIC_DMEM = 8'h5A;

  state_t      state, state_nxt;
  logic        tgt_imem;
  logic [15:0] cnt, idx, wr_idx;
  logic [7:0]  csum;
  logic [1:0]  bcnt;
  logic [31:0] shreg, wr_data, timer, lim;
  logic        imem_we_r, dmem_we_r;
  logic        is_magic, tmo, last_word;
  logic [15:0] n_req;

  assign is_magic  = (rx_data == MAGIC_IMEM) || (rx_data == MAGIC_DMEM);
  assign n_req     = {rx_data, cnt[7:0]};
  assign lim       = tgt_imem ? 32'(IMEM_WORDS) : 32'(DMEM_WORDS);
  assign last_word = (bcnt == 2'd3) && ((idx + 16'd1) == cnt);
  // A byte arriving on the terminal-count cycle wins over the timeout.
  assign tmo       = (state != IDLE) && (state != ERR) && !rx_valid && (timer == TIMEOUT - 32'd1);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (rx_valid && is_magic) state_nxt = LEN0;
      LEN0: if (rx_valid) state_nxt = LEN1;
      LEN1: if (rx_valid) begin
        if ({16'd0, n_req} > lim) state_nxt = ERR;
        else if (n_req == 16'd0)  state_nxt = CSUM;
        else                      state_nxt = DATA;
      end
      DATA: if (rx_valid && last_word) state_nxt = CSUM;
      CSUM: if (rx_valid) state_nxt = (rx_data == csum) ? IDLE : ERR;
      ERR:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (tmo) state_nxt = ERR;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      tgt_imem  <= 1'b0;
      cnt       <= '0;
      idx       <= '0;
      wr_idx    <= '0;
      csum      <= '0;
      bcnt      <= '0;
      shreg     <= '0;
      wr_data   <= '0;
      timer     <= '0;
      imem_we_r <= 1'b0;
      dmem_we_r <= 1'b0;
      core_run  <= 1'b1;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      state     <= state_nxt;
      imem_we_r <= 1'b0;
      dmem_we_r <= 1'b0;
      load_done <= 1'b0;
      timer     <= (state == IDLE || rx_valid) ? 32'd0 : timer + 32'd1;
      case (state)
        IDLE: if (rx_valid && is_magic) begin
          core_run <= 1'b0;
          load_err <= 1'b0;
          tgt_imem <= (rx_data == MAGIC_IMEM);
          idx      <= '0;
          csum     <= '0;
          bcnt     <= '0;
        end
        LEN0: if (rx_valid) begin
          cnt[7:0] <= rx_data;
          csum     <= csum + rx_data;
        end
        LEN1: if (rx_valid) begin
          cnt[15:8] <= rx_data;
          csum      <= csum + rx_data;
        end
        DATA: if (rx_valid) begin
          shreg <= {rx_data, shreg[31:8]};
          csum  <= csum + rx_data;
          bcnt  <= bcnt + 2'd1;
          if (bcnt == 2'd3) begin
            wr_data   <= {rx_data, shreg[31:8]};
            wr_idx    <= idx;
            imem_we_r <= tgt_imem;
            dmem_we_r <= !tgt_imem;
            idx       <= idx + 16'd1;
          end
        end
        CSUM: if (rx_valid && rx_data == csum) begin
          core_run  <= 1'b1;
          load_done <= 1'b1;
        end
        ERR: load_err <= 1'b1;
        default: ;
      endcase
    end
  end

  assign busy       = (state != IDLE);
  assign imem_we    = imem_we_r;
  assign imem_addr  = wr_idx[AW-1:0];
  assign imem_wdata = wr_data;

  // Core owns the port while running; otherwise only loader write cycles reach memory.
  always_comb begin
    if (core_run) begin
      mem_we    = core_we;
      mem_ctrl  = core_mem_ctrl;
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
    end else begin
      mem_we    = dmem_we_r;
      mem_ctrl  = 2'b10;
      mem_addr  = DMEM_BASE + {14'd0, wr_idx, 2'b00};
      mem_wdata = wr_data;
    end
  end

endmodule

// File: tb/tb_fw_load_ctrl.sv
// Scoreboard bench for fw_load_ctrl: stimulus pushes expected events, a monitor pops and compares.
module tb_fw_load_ctrl;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [7:0]    rx_data = '0;
  logic          rx_valid = 1'b0;
  logic          core_we = 1'b0;
  logic [1:0]    core_mem_ctrl = '0;
  logic [31:0]   core_addr = '0, core_wdata = '0;
  logic          mem_we, imem_we, core_run, busy, load_done, load_err;
  logic [1:0]    mem_ctrl;
  logic [31:0]   mem_addr, mem_wdata, imem_wdata;
  logic [AW-1:0] imem_addr;

  fw_load_ctrl #(.IMEM_WORDS(256), .DMEM_WORDS(256), .DMEM_BASE(32'h0000_0000),
                 .TIMEOUT(32'd100)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .core_we(core_we), .core_mem_ctrl(core_mem_ctrl), .core_addr(core_addr),
    .core_wdata(core_wdata), .mem_we(mem_we), .mem_ctrl(mem_ctrl), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .core_run(core_run), .busy(busy),
    .load_done(load_done), .load_err(load_err));

  always #5 clk = ~clk;

  // kind: 0 imem write, 1 dmem write, 2 load_done (d = core_run), 3 load_err rising
  typedef struct {
    int          kind;
    logic [31:0] a;
    logic [31:0] d;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] fr[$];
  int         n_cmp = 0, n_bad = 0;
  logic       err_q = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic push(input int kind, input logic [31:0] a, input logic [31:0] d);
    ev_t e;
    e.kind = kind; e.a = a; e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic got(input int kind, input logic [31:0] a, input logic [31:0] d);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL unexpected_event: got kind %0d a=%h d=%h, expected none", kind, a, d);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", 32'(kind), 32'(e.kind));
      chk("event_addr", a, e.a);
      chk("event_data", d, e.d);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      if (imem_we) got(0, {24'd0, imem_addr}, imem_wdata);
      if (!core_run && mem_we) begin
        got(1, mem_addr, mem_wdata);
        chk("mem_ctrl_word", {30'd0, mem_ctrl}, 32'd2);
      end
      if (load_done) got(2, 32'd0, {31'd0, core_run});
      if (load_err && !err_q) got(3, 32'd0, 32'd0);
      err_q = load_err;
    end
  end

  task automatic send(input bit b2b);
    foreach (fr[i]) begin
      @(negedge clk);
      rx_data = fr[i]; rx_valid = 1'b1;
      if (!b2b) begin
        @(negedge clk);
        rx_valid = 1'b0;
      end
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit seen;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_core_run", {31'd0, core_run}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_load_err", {31'd0, load_err}, 32'd0);
    chk("rst_imem_we", {31'd0, imem_we}, 32'd0);

    core_we = 1'b1; core_addr = 32'h10; core_wdata = 32'hDEADBEEF; core_mem_ctrl = 2'b01;
    #1;
    chk("mux_we", {31'd0, mem_we}, 32'd1);
    chk("mux_addr", mem_addr, 32'h10);
    chk("mux_wdata", mem_wdata, 32'hDEADBEEF);
    chk("mux_ctrl", {30'd0, mem_ctrl}, 32'd1);

    // Two-word imem image, spaced bytes
    push(0, 32'd0, 32'h0000_0013);
    push(0, 32'd1, 32'h0010_0093);
    push(2, 32'd0, 32'd1);
    fr = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
           8'h93, 8'h00, 8'h10, 8'h00, 8'hB8};
    send(1'b0);
    idle(4);
    chk("f1_core_run", {31'd0, core_run}, 32'd1);

    // Data-RAM word, back-to-back, core keeps trying to write elsewhere
    core_addr = 32'h44; core_wdata = 32'hCAFEF00D;
    push(1, 32'h0000_0000, 32'h1234_5678);
    push(2, 32'd0, 32'd1);
    fr = '{8'h5A, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h15};
    send(1'b1);
    idle(4);
    core_we = 1'b0;

    // Bad checksum, then good frame clears the error
    push(0, 32'd0, 32'h0403_0201);
    push(3, 32'd0, 32'd0);
    fr = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00};
    send(1'b1);
    idle(4);
    chk("bad_cs_err", {31'd0, load_err}, 32'd1);
    chk("bad_cs_held", {31'd0, core_run}, 32'd0);
    push(0, 32'd0, 32'h0403_0201);
    push(2, 32'd0, 32'd1);
    fr = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0B};
    send(1'b1);
    idle(4);
    chk("recover_err", {31'd0, load_err}, 32'd0);
    chk("recover_run", {31'd0, core_run}, 32'd1);

    // Zero-length frame: straight to checksum
    push(2, 32'd0, 32'd1);
    fr = '{8'hA5, 8'h00, 8'h00, 8'h00};
    send(1'b1);
    idle(4);

    // N = 257 exceeds imem limit
    push(3, 32'd0, 32'd0);
    fr = '{8'hA5, 8'h01, 8'h01};
    send(1'b1);
    idle(4);
    chk("limit_err", {31'd0, load_err}, 32'd1);
    chk("limit_busy", {31'd0, busy}, 32'd0);

    // Timeout: load_err appears 101 edges after the last byte's edge
    push(3, 32'd0, 32'd0);
    fr = '{8'hA5, 8'h03};
    send(1'b1);
    n = 0; seen = 1'b0;
    while (!seen && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (load_err) seen = 1'b1;
    end
    chk("timeout_cycles", 32'(n), 32'd101);
    chk("timeout_held", {31'd0, core_run}, 32'd0);

    // Reset in the middle of DATA
    push(0, 32'd0, 32'h0000_0013);
    fr = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93};
    send(1'b1);
    @(negedge clk);
    reset = 1'b0;
    core_we = 1'b1; core_addr = 32'h20; core_wdata = 32'h0BAD_F00D; core_mem_ctrl = 2'b00;
    @(posedge clk); #1;
    chk("midrst_run", {31'd0, core_run}, 32'd1);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_err", {31'd0, load_err}, 32'd0);
    chk("midrst_imem_we", {31'd0, imem_we}, 32'd0);
    chk("midrst_mem_addr", mem_addr, 32'h20);
    chk("midrst_mem_wdata", mem_wdata, 32'h0BAD_F00D);
    @(negedge clk);
    reset = 1'b1;
    idle(4);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
